ysyx_rd_arb: RTL and testbench

- Read-channel arbiter that shares the single AXI4 master read path (AR/R) between the instruction fetch requester (IFU) and the load requester (LSU).
- Sits between IFU/LSU and the AXI master port, beside the write path.
- Issues single-beat reads (arlen=0) and routes each response to its owner.
- Drops IFU responses cancelled by speculation flush.
- Holds loads back while a store is outstanding, which preserves store-to-load ordering.

---
 rtl/ysyx_rd_arb.sv | 135 +++++++++++++
 tb/tb_ysyx_rd_arb.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_rd_arb.sv
// ysyx_rd_arb: shares one AXI4 single-beat read channel between IFU fetches and LSU loads.
// Define YSYX_RD_ARB_LSU_PRIO_EN for fixed LSU-over-IFU priority (default: round-robin).
module ysyx_rd_arb #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 64,
  parameter logic [2:0]  IFU_ARSIZE = 3'b010
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_arvalid,
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic              ifu_flush,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic              ifu_rvalid,
  input  logic              lsu_arvalid,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic [2:0]        lsu_arsize,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_rvalid,
  input  logic              wr_busy,
  output logic              rd_err_o,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [2:0]        m_arsize,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_e;
  typedef enum logic {OWN_IFU, OWN_LSU} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_q, last_d;
  logic              drop_q, drop_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        size_q, size_d;
  logic [DATA_W-1:0] ifu_rdata_q, ifu_rdata_d;
  logic [DATA_W-1:0] lsu_rdata_q, lsu_rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              ifu_el, lsu_el, gnt_lsu;

  assign ifu_el = ifu_arvalid;
  // wr_busy only gates new grants; a load already past IDLE is unaffected.
  assign lsu_el = lsu_arvalid && !wr_busy;

`ifdef YSYX_RD_ARB_LSU_PRIO_EN
  assign gnt_lsu = lsu_el;
`else
  assign gnt_lsu = lsu_el && (!ifu_el || (last_q == OWN_IFU));
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    drop_d      = drop_q;
    addr_d      = addr_q;
    size_d      = size_q;
    ifu_rdata_d = ifu_rdata_q;
    lsu_rdata_d = lsu_rdata_q;
    rresp_d     = rresp_q;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    ifu_rvalid  = 1'b0;
    lsu_rvalid  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ifu_el || lsu_el) begin
          owner_d = gnt_lsu ? OWN_LSU : OWN_IFU;
          last_d  = owner_d;
          drop_d  = 1'b0;
          addr_d  = gnt_lsu ? lsu_araddr : ifu_araddr;
          size_d  = gnt_lsu ? lsu_arsize : IFU_ARSIZE;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        m_arvalid = 1'b1;
        if (ifu_flush && (owner_q == OWN_IFU)) drop_d = 1'b1;
        if (m_arready) state_d = S_DATA;
      end
      S_DATA: begin
        m_rready = 1'b1;
        if (ifu_flush && (owner_q == OWN_IFU)) drop_d = 1'b1;
        if (m_rvalid) begin
          if (owner_q == OWN_IFU) ifu_rdata_d = m_rdata;
          else                    lsu_rdata_d = m_rdata;
          rresp_d = m_rresp;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        ifu_rvalid = (owner_q == OWN_IFU) && !drop_q && !ifu_flush;
        lsu_rvalid = (owner_q == OWN_LSU);
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IFU;
      last_q      <= OWN_LSU;
      drop_q      <= 1'b0;
      addr_q      <= '0;
      size_q      <= '0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
      rresp_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      drop_q      <= drop_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
      rresp_q     <= rresp_d;
    end
  end

  assign m_araddr  = addr_q;
  assign m_arsize  = size_q;
  assign ifu_rdata = ifu_rdata_q;
  assign lsu_rdata = lsu_rdata_q;
  assign rd_err_o  = (rresp_q != 2'b00) && (ifu_rvalid || lsu_rvalid);

endmodule

// File: tb/tb_ysyx_rd_arb.sv
// Scoreboard bench for ysyx_rd_arb: expected AR beats and responses are queued as requests are driven.
module tb_ysyx_rd_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_arvalid, ifu_flush, ifu_rvalid;
  logic [31:0] ifu_araddr;
  logic [63:0] ifu_rdata;
  logic        lsu_arvalid, lsu_rvalid;
  logic [31:0] lsu_araddr;
  logic [2:0]  lsu_arsize;
  logic [63:0] lsu_rdata;
  logic        wr_busy, rd_err_o;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_araddr;
  logic [2:0]  m_arsize;
  logic [63:0] m_rdata;
  logic [1:0]  m_rresp;

  always #5 clk = ~clk;

  ysyx_rd_arb #(.ADDR_W(32), .DATA_W(64), .IFU_ARSIZE(3'b010)) dut (
    .clk(clk), .rst(rst),
    .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_flush(ifu_flush),
    .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid),
    .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize),
    .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
    .wr_busy(wr_busy), .rd_err_o(rd_err_o),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arsize(m_arsize),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
  );

  typedef struct packed { logic lsu; logic [63:0] data; logic err; } resp_t;
  typedef struct packed { logic [31:0] addr; logic [2:0] size; } ar_t;

  resp_t       resp_q[$];
  ar_t         ar_q[$];
  int          checks = 0;
  int          failures = 0;
  bit          sl_en = 1'b1;
  int          sl_phase = 0, sl_cnt = 0, ar_delay = 0, r_delay = 0, r_hs = 0;
  logic [31:0] sl_addr, err_addr = 32'hFFFF_FFF0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sl_data(input logic [31:0] a);
    if (a == 32'h3000_0000) return 64'h0000_0413_0000_0297;
    return {~a, a};
  endfunction

  task automatic push_ar(input logic [31:0] addr, input logic [2:0] size);
    ar_t a;
    a.addr = addr; a.size = size;
    ar_q.push_back(a);
  endtask

  task automatic push_exp(input logic lsu, input logic [31:0] addr, input logic [2:0] size);
    resp_t r;
    push_ar(addr, size);
    r.lsu = lsu; r.data = sl_data(addr); r.err = (addr == err_addr);
    resp_q.push_back(r);
  endtask

  task automatic sl_reset();
    sl_phase = 0; sl_cnt = 0; m_arready = 1'b0; m_rvalid = 1'b0;
  endtask

  // Slave: inputs change only at negedge, so a handshake seen there completes at the next posedge.
  initial begin
    ar_t a;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;
    forever begin
      @(negedge clk);
      if (sl_en) begin
        case (sl_phase)
          0: if (m_arvalid) begin
               if (sl_cnt >= ar_delay) begin
                 m_arready = 1'b1; sl_addr = m_araddr; sl_phase = 1;
                 if (ar_q.size() == 0) check_eq("unexp_ar", m_araddr, 32'hx);
                 else begin
                   a = ar_q.pop_front();
                   check_eq("ar_addr", m_araddr, a.addr);
                   check_eq("ar_size", m_arsize, a.size);
                 end
               end else sl_cnt++;
             end
          1: begin m_arready = 1'b0; sl_cnt = 0; sl_phase = 2; end
          2: if (sl_cnt >= r_delay) begin
               check_eq("rready_in_data", m_rready, 1);
               m_rvalid = 1'b1; m_rdata = sl_data(sl_addr);
               m_rresp = (sl_addr == err_addr) ? 2'b10 : 2'b00;
               sl_phase = 3;
             end else sl_cnt++;
          default: begin m_rvalid = 1'b0; r_hs++; sl_phase = 0; sl_cnt = 0; end
        endcase
      end
    end
  end

  // Response monitor; requesters drop arvalid on the negedge inside the pulse cycle.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (ifu_rvalid || lsu_rvalid) begin
        if (resp_q.size() == 0) check_eq("unexp_rvalid", {ifu_rvalid, lsu_rvalid}, 0);
        else begin
          r = resp_q.pop_front();
          check_eq("r_ifu_pulse", ifu_rvalid, !r.lsu);
          check_eq("r_lsu_pulse", lsu_rvalid, r.lsu);
          check_eq("r_data", r.lsu ? lsu_rdata : ifu_rdata, r.data);
          check_eq("r_err", rd_err_o, r.err);
        end
        if (ifu_rvalid) ifu_arvalid = 1'b0;
        if (lsu_rvalid) lsu_arvalid = 1'b0;
      end else if (rd_err_o) check_eq("err_without_pulse", rd_err_o, 0);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ifu_arvalid = 1'b0; lsu_arvalid = 1'b0; ifu_flush = 1'b0; wr_busy = 1'b0;
    sl_reset(); ar_q.delete(); resp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((ar_q.size() != 0 || resp_q.size() != 0 || sl_phase != 0) && n < 300) begin
      @(negedge clk); n++;
    end
    check_eq({tag, "_in_time"}, n < 300, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    int h0;
    rst = 1'b0; ifu_arvalid = 1'b0; ifu_araddr = '0; ifu_flush = 1'b0;
    lsu_arvalid = 1'b0; lsu_araddr = '0; lsu_arsize = '0; wr_busy = 1'b0;

    do_reset();
    check_eq("rst_arvalid", m_arvalid, 0);
    check_eq("rst_rready", m_rready, 0);
    check_eq("rst_ifu_rvalid", ifu_rvalid, 0);
    check_eq("rst_lsu_rvalid", lsu_rvalid, 0);
    check_eq("rst_err", rd_err_o, 0);
    check_eq("rst_araddr", m_araddr, 0);
    check_eq("rst_ifu_rdata", ifu_rdata, 0);
    check_eq("rst_lsu_rdata", lsu_rdata, 0);

    // Fetch path
    ar_delay = 2; r_delay = 0;
    push_exp(1'b0, 32'h3000_0000, 3'd2);
    ifu_araddr = 32'h3000_0000; ifu_arvalid = 1'b1;
    @(negedge clk);
    check_eq("ar_latency", m_arvalid, 1);
    wait_done("fetch");
    check_eq("ifu_rdata_hold", ifu_rdata, 64'h0000_0413_0000_0297);

    // Arbitration, twice with simultaneous requests
    do_reset();
    ar_delay = 0;
    for (int k = 0; k < 2; k++) begin
`ifdef YSYX_RD_ARB_LSU_PRIO_EN
      push_exp(1'b1, 32'h8000_0010, 3'd3);
      push_exp(1'b0, 32'h3000_0004, 3'd2);
`else
      push_exp(1'b0, 32'h3000_0004, 3'd2);
      push_exp(1'b1, 32'h8000_0010, 3'd3);
`endif
      ifu_araddr = 32'h3000_0004; ifu_arvalid = 1'b1;
      lsu_araddr = 32'h8000_0010; lsu_arsize = 3'd3; lsu_arvalid = 1'b1;
      wait_done("arb");
    end

    // Store ordering
    wr_busy = 1'b1;
    push_exp(1'b0, 32'h3000_000C, 3'd2);
    ifu_araddr = 32'h3000_000C; ifu_arvalid = 1'b1;
    lsu_araddr = 32'h8000_0020; lsu_arsize = 3'd3; lsu_arvalid = 1'b1;
    wait_done("store_ifu");
    repeat (4) @(negedge clk);
    check_eq("lsu_held_by_wr_busy", m_arvalid, 0);
    push_exp(1'b1, 32'h8000_0020, 3'd3);
    wr_busy = 1'b0;
    wait_done("store_lsu");

    // Flush during DATA
    r_delay = 3;
    push_ar(32'h3000_0008, 3'd2);
    ifu_araddr = 32'h3000_0008; ifu_arvalid = 1'b1;
    h0 = r_hs;
    n = 0;
    while (!m_rready && n < 50) begin @(negedge clk); n++; end
    check_eq("flush_reach_data", n < 50, 1);
    ifu_flush = 1'b1;
    @(negedge clk);
    ifu_flush = 1'b0; ifu_arvalid = 1'b0;
    wait_done("flush");
    check_eq("flush_r_handshake", r_hs, h0 + 1);
    r_delay = 0;
    push_exp(1'b1, 32'h8000_0030, 3'd2);
    lsu_araddr = 32'h8000_0030; lsu_arsize = 3'd2; lsu_arvalid = 1'b1;
    wait_done("post_flush_lsu");

    // Error response still delivers data
    err_addr = 32'h8000_0040;
    push_exp(1'b1, 32'h8000_0040, 3'd3);
    lsu_araddr = 32'h8000_0040; lsu_arsize = 3'd3; lsu_arvalid = 1'b1;
    wait_done("err");
    err_addr = 32'hFFFF_FFF0;

    // Async reset in ADDR
    ar_delay = 5;
    ifu_araddr = 32'h3000_0010; ifu_arvalid = 1'b1;
    n = 0;
    while (!m_arvalid && n < 20) begin @(negedge clk); n++; end
    check_eq("rst_reach_addr", m_arvalid, 1);
    #2;
    sl_en = 1'b0; rst = 1'b1; ifu_arvalid = 1'b0; sl_reset();
    #1;
    check_eq("async_rst_arvalid", m_arvalid, 0);
    @(negedge clk);
    rst = 1'b0;
    m_rvalid = 1'b1; m_rdata = 64'hDEAD_BEEF_0BAD_F00D; m_rresp = 2'b10;
    repeat (3) @(negedge clk);
    check_eq("stray_r_rready", m_rready, 0);
    m_rvalid = 1'b0;
    @(negedge clk);
    sl_en = 1'b1; ar_delay = 1;
    push_exp(1'b0, 32'h3000_0014, 3'd2);
    ifu_araddr = 32'h3000_0014; ifu_arvalid = 1'b1;
    wait_done("post_rst_ifu");

    check_eq("resp_q_empty", resp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
